mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 190 +++++++++++++++++++
 tb/tb_mc_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute and owns the NZCV Flags register.
// Optional condition-code evaluation is enabled with the macro MC_CTRL_COND_EXEC_EN.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_ORR = 3'b011
    } alu_op_t;

    state_t     state, state_n;
    logic [3:0] flags;
    logic       cond_ex;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       i_bit, s_bit, u_bit, is_cmp, is_rd_pc;
    alu_op_t    dp_op;
    logic       cmd_ok;

    assign op       = Instr[27:26];
    assign i_bit    = Instr[25];
    assign u_bit    = Instr[23];
    assign cmd      = Instr[24:21];
    assign s_bit    = Instr[20];
    assign is_cmp   = (cmd == 4'b1010);
    assign is_rd_pc = (Instr[15:12] == 4'hF);

    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    always_comb begin
        dp_op  = ALU_ADD;
        cmd_ok = 1'b1;
        unique case (cmd)
            4'b0100: dp_op = ALU_ADD;
            4'b0010: dp_op = ALU_SUB;
            4'b0000: dp_op = ALU_AND;
            4'b1100: dp_op = ALU_ORR;
            4'b1010: dp_op = ALU_SUB;
            default: cmd_ok = 1'b0;
        endcase
    end

`ifdef MC_CTRL_COND_EXEC_EN
    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = flags;

    always_comb begin
        cond_ex = 1'b1;
        unique case (Instr[31:28])
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            default: cond_ex = 1'b1;   // AL, and 1111 behaves as AL
        endcase
    end
`else
    logic unused_cond_bits;
    assign unused_cond_bits = ^Instr[31:28];
    assign cond_ex = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            flags <= 4'b0000;
        end else begin
            state <= state_n;
            if ((state == EXECR || state == EXECI) && cmd_ok && (s_bit || is_cmp) && cond_ex)
                flags <= ALUFlags;
        end
    end

    logic fetch_pcw, pc_we, reg_we, mem_we, ir_we;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        fetch_pcw  = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        unique case (state)
            FETCH: begin
                ir_we     = 1'b1;
                fetch_pcw = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_n   = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (op == 2'b01)      state_n = MEMADR;
                else if (op == 2'b10) state_n = BRANCH;
                else if (i_bit)       state_n = EXECI;
                else                  state_n = EXECR;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = u_bit ? ALU_ADD : ALU_SUB;
                state_n    = Instr[20] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_n = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_we    = 1'b1;
                state_n   = FETCH;
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                mem_we  = 1'b1;
                state_n = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
                ALUControl = dp_op;
                state_n    = ALUWB;
            end
            ALUWB: begin
                ALUControl = dp_op;
                reg_we     = cmd_ok && !is_cmp;
                pc_we      = cmd_ok && !is_cmp && is_rd_pc;
                state_n    = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_we     = 1'b1;
                state_n   = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    // Reset forces the write enables low without waiting for a clock edge.
    assign PCWrite  = reset & (fetch_pcw | (pc_we & cond_ex));
    assign IRWrite  = reset & ir_we;
    assign RegWrite = reset & reg_we & cond_ex;
    assign MemWrite = reset & mem_we & cond_ex;

    assign ImmSrc = Instr[27:26];
    assign RegSrc = {op == 2'b01, op == 2'b10};
    assign State  = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller; expectations adapt to MC_CTRL_COND_EXEC_EN.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;

    int total = 0;
    int bad   = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; Instr = 32'hE5912000; ALUFlags = 4'b0000;
        repeat (3) tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL reset_state got=%0h want=0", State); end
        total++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin bad++;
            $display("FAIL reset_enables got=%b want=0000", {PCWrite, IRWrite, RegWrite, MemWrite}); end
        total++; if (dut.flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", dut.flags); end
        reset = 1'b1; #1;
        total++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin bad++;
            $display("FAIL release_fetch got=%b%b want=11", IRWrite, PCWrite); end
        tick();
        total++; if (State !== 4'd1) begin bad++; $display("FAIL release_decode got=%0h want=1", State); end
        tick();
        total++; if (State !== 4'd2) begin bad++; $display("FAIL release_memadr got=%0h want=2", State); end
        total++; if ({ALUSrcA, ALUSrcB, ALUControl} !== {1'b0, 2'b01, 3'b000}) begin bad++;
            $display("FAIL ldr_memadr_ctl got=%b want=001000", {ALUSrcA, ALUSrcB, ALUControl}); end
        // Abort mid-instruction: reset must take effect without a clock edge.
        #2 reset = 1'b0; #1;
        total++; if (State !== 4'd0 || PCWrite !== 1'b0 || IRWrite !== 1'b0) begin bad++;
            $display("FAIL async_reset got=%0h/%b%b want=0/00", State, PCWrite, IRWrite); end
        tick();
        reset = 1'b1;
        tick();
        total++; if (State !== 4'd1) begin bad++; $display("FAIL rerelease_decode got=%0h want=1", State); end
        tick(); tick();
        total++; if (State !== 4'd3 || AdrSrc !== 1'b1) begin bad++;
            $display("FAIL ldr_memrd got=%0h/%b want=3/1", State, AdrSrc); end
        tick();
        total++; if (State !== 4'd4 || ResultSrc !== 2'b01 || RegWrite !== 1'b1) begin bad++;
            $display("FAIL ldr_memwb got=%0h/%b/%b want=4/01/1", State, ResultSrc, RegWrite); end
        tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL ldr_return got=%0h want=0", State); end
    endtask

    task automatic test_add_imm();
        Instr = 32'hE2821005; ALUFlags = 4'b1111; #1;
        total++; if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl} !== {1'b0, 1'b1, 2'b10, 2'b10, 3'b000}) begin bad++;
            $display("FAIL fetch_ctl got=%b want=0110 10000", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}); end
        tick();
        total++; if (State !== 4'd1 || PCWrite !== 1'b0 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10) begin bad++;
            $display("FAIL add_decode got=%0h/%b/%b/%b want=1/0/1/10", State, PCWrite, ALUSrcA, ALUSrcB); end
        tick();
        total++; if (State !== 4'd7 || ALUSrcA !== 1'b0 || ALUSrcB !== 2'b01 || ALUControl !== 3'b000) begin bad++;
            $display("FAIL add_execi got=%0h/%b/%b/%b want=7/0/01/000", State, ALUSrcA, ALUSrcB, ALUControl); end
        tick();
        total++; if (State !== 4'd8 || RegWrite !== 1'b1 || ResultSrc !== 2'b00 || ALUControl !== 3'b000 || PCWrite !== 1'b0) begin bad++;
            $display("FAIL add_aluwb got=%0h/%b/%b/%b/%b want=8/1/00/000/0", State, RegWrite, ResultSrc, ALUControl, PCWrite); end
        total++; if (dut.flags !== 4'b0000) begin bad++; $display("FAIL add_no_s_flags got=%b want=0000", dut.flags); end
        tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL add_return got=%0h want=0", State); end
    endtask

    task automatic test_str();
        logic rw_seen;
        rw_seen = 1'b0;
        Instr = 32'hE5812004; ALUFlags = 4'b0000; #1;
        rw_seen |= RegWrite;
        tick(); rw_seen |= RegWrite;
        tick(); rw_seen |= RegWrite;
        total++; if (State !== 4'd2) begin bad++; $display("FAIL str_memadr got=%0h want=2", State); end
        tick(); rw_seen |= RegWrite;
        total++; if (State !== 4'd5 || MemWrite !== 1'b1 || AdrSrc !== 1'b1) begin bad++;
            $display("FAIL str_memwr got=%0h/%b/%b want=5/1/1", State, MemWrite, AdrSrc); end
        total++; if (RegSrc !== 2'b10 || ImmSrc !== 2'b01) begin bad++;
            $display("FAIL str_srcs got=%b/%b want=10/01", RegSrc, ImmSrc); end
        tick();
        total++; if (State !== 4'd0 || MemWrite !== 1'b0) begin bad++;
            $display("FAIL str_return got=%0h/%b want=0/0", State, MemWrite); end
        total++; if (rw_seen !== 1'b0) begin bad++; $display("FAIL str_regwrite got=%b want=0", rw_seen); end
    endtask

    task automatic test_cmp_beq();
        Instr = 32'hE1510001; ALUFlags = 4'b0000; #1;
        tick(); tick();
        total++; if (State !== 4'd6 || ALUSrcB !== 2'b00 || ALUControl !== 3'b001) begin bad++;
            $display("FAIL cmp_execr got=%0h/%b/%b want=6/00/001", State, ALUSrcB, ALUControl); end
        ALUFlags = 4'b0100;
        tick();
        ALUFlags = 4'b0000;
        total++; if (dut.flags !== 4'b0100) begin bad++; $display("FAIL cmp_flags got=%b want=0100", dut.flags); end
        total++; if (State !== 4'd8 || RegWrite !== 1'b0 || PCWrite !== 1'b0) begin bad++;
            $display("FAIL cmp_aluwb got=%0h/%b/%b want=8/0/0", State, RegWrite, PCWrite); end
        tick();
        Instr = 32'h0A000002; #1;
        tick(); tick();
        total++; if (State !== 4'd9 || PCWrite !== 1'b1) begin bad++;
            $display("FAIL beq_branch got=%0h/%b want=9/1", State, PCWrite); end
        total++; if ({ALUSrcA, ALUSrcB, ALUControl, ResultSrc, RegSrc} !== {1'b0, 2'b01, 3'b000, 2'b10, 2'b01}) begin bad++;
            $display("FAIL beq_ctl got=%b want=00100010 01", {ALUSrcA, ALUSrcB, ALUControl, ResultSrc, RegSrc}); end
        tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL beq_return got=%0h want=0", State); end
    endtask

    task automatic test_subs_bne();
        logic exp_pcw;
`ifdef MC_CTRL_COND_EXEC_EN
        exp_pcw = 1'b0;
`else
        exp_pcw = 1'b1;
`endif
        Instr = 32'hE2511001; ALUFlags = 4'b0000; #1;
        tick(); tick();
        total++; if (State !== 4'd7 || ALUControl !== 3'b001) begin bad++;
            $display("FAIL subs_execi got=%0h/%b want=7/001", State, ALUControl); end
        ALUFlags = 4'b0100;
        tick();
        ALUFlags = 4'b0000;
        total++; if (dut.flags !== 4'b0100 || RegWrite !== 1'b1) begin bad++;
            $display("FAIL subs_aluwb got=%b/%b want=0100/1", dut.flags, RegWrite); end
        tick();
        Instr = 32'h1A000002; #1;
        tick(); tick();
        total++; if (State !== 4'd9 || PCWrite !== exp_pcw) begin bad++;
            $display("FAIL bne_branch got=%0h/%b want=9/%b", State, PCWrite, exp_pcw); end
        tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL bne_return got=%0h want=0", State); end
    endtask

    task automatic test_undefined_cmd();
        Instr = 32'hE0311002; ALUFlags = 4'b0000; #1;
        tick(); tick();
        total++; if (State !== 4'd6 || ALUControl !== 3'b000) begin bad++;
            $display("FAIL eors_execr got=%0h/%b want=6/000", State, ALUControl); end
        ALUFlags = 4'b1001;
        tick();
        ALUFlags = 4'b0000;
        total++; if (dut.flags !== 4'b0100 || RegWrite !== 1'b0 || PCWrite !== 1'b0) begin bad++;
            $display("FAIL eors_suppressed got=%b/%b/%b want=0100/0/0", dut.flags, RegWrite, PCWrite); end
        tick();
    endtask

    task automatic test_pc_dest();
        Instr = 32'hE28FF000; ALUFlags = 4'b0000; #1;
        tick(); tick(); tick();
        total++; if (State !== 4'd8 || RegWrite !== 1'b1 || PCWrite !== 1'b1) begin bad++;
            $display("FAIL pc_dest_aluwb got=%0h/%b/%b want=8/1/1", State, RegWrite, PCWrite); end
        tick();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL pc_dest_return got=%0h want=0", State); end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_str();
        test_cmp_beq();
        test_subs_bne();
        test_undefined_cmd();
        test_pc_dest();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
